// File: rtl/rf_wb_arb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_wb_arb_pkg;
  localparam int RF_ADDR_W  = 5;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_MIN  = 2;
  localparam int DEPTH_MAX  = 8;
  localparam int CNT_W      = 4;
  localparam int NUM_SRC    = 2;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;
endpackage

// File: rtl/rf_wb_fifo.sv
// Per-source writeback queue storing {WR, WD}; exposes entries in age order
// (index 0 = head/oldest) so the top can search them for forwarding.
module rf_wb_fifo
  import rf_wb_arb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic [RF_ADDR_W-1:0]                 push_wr,
  input  logic [DATA_W-1:0]                    push_wd,
  input  logic                                 pop,
  output logic                                 full,
  output logic                                 empty,
  output logic [CNT_W-1:0]                     count,
  output logic [DEPTH-1:0]                     ent_vld,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]      ent_wr,
  output logic [DEPTH-1:0][DATA_W-1:0]         ent_wd
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][RF_ADDR_W-1:0] mem_wr;
  logic [DEPTH-1:0][DATA_W-1:0]    mem_wd;
  logic [PTR_W-1:0]                rd_ptr, wr_ptr;
  logic                            do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_wr[wr_ptr] <= push_wr;
      mem_wd[wr_ptr] <= push_wd;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] idx;
    assign idx        = rd_ptr + PTR_W'(i);
    assign ent_vld[i] = (CNT_W'(i) < count);
    assign ent_wr[i]  = mem_wr[idx];
    assign ent_wd[i]  = mem_wd[idx];
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-source register-file writeback arbiter with queued sources and a
// registered write port. Define RF_WB_ARB_FWD_EN to build forwarding lookup.
module rf_wb_arbiter
  import rf_wb_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [RF_ADDR_W-1:0] a_WR,
  input  logic [DATA_W-1:0]    a_WD,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [RF_ADDR_W-1:0] b_WR,
  input  logic [DATA_W-1:0]    b_WD,
  output logic                 b_ready,
  output logic                 write,
  output logic [RF_ADDR_W-1:0] WR,
  output logic [DATA_W-1:0]    WD,
  output logic [CNT_W-1:0]     pend_cnt,
  output logic                 busy,
  input  logic [RF_ADDR_W-1:0] PR1,
  input  logic [RF_ADDR_W-1:0] PR2,
  output logic                 fwd1_hit,
  output logic [DATA_W-1:0]    fwd1_data,
  output logic                 fwd2_hit,
  output logic [DATA_W-1:0]    fwd2_data
);
  logic [NUM_SRC-1:0]                               src_valid, src_ready, src_push;
  logic [NUM_SRC-1:0]                               src_pop, src_full, src_empty;
  logic [NUM_SRC-1:0][RF_ADDR_W-1:0]                src_wr, head_wr;
  logic [NUM_SRC-1:0][DATA_W-1:0]                   src_wd, head_wd;
  logic [NUM_SRC-1:0][CNT_W-1:0]                    src_cnt;
  logic [NUM_SRC-1:0][DEPTH-1:0]                    ent_vld;
  logic [NUM_SRC-1:0][DEPTH-1:0][RF_ADDR_W-1:0]     ent_wr;
  logic [NUM_SRC-1:0][DEPTH-1:0][DATA_W-1:0]        ent_wd;

  assign src_valid = {b_valid, a_valid};
  assign src_wr    = {b_WR, a_WR};
  assign src_wd    = {b_WD, a_WD};
  assign a_ready   = src_ready[SRC_A];
  assign b_ready   = src_ready[SRC_B];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign src_ready[s] = ~src_full[s] & ~rst;
    // Writes to x0 complete the handshake but are dropped here.
    assign src_push[s]  = src_valid[s] & src_ready[s] & (src_wr[s] != '0);
    assign head_wr[s]   = ent_wr[s][0];
    assign head_wd[s]   = ent_wd[s][0];

    rf_wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (src_push[s]),
      .push_wr (src_wr[s]),
      .push_wd (src_wd[s]),
      .pop     (src_pop[s]),
      .full    (src_full[s]),
      .empty   (src_empty[s]),
      .count   (src_cnt[s]),
      .ent_vld (ent_vld[s]),
      .ent_wr  (ent_wr[s]),
      .ent_wd  (ent_wd[s])
    );
  end

  src_e rr_last;
  src_e gnt_src;
  logic gnt_vld, contested;

  assign contested = ~src_empty[SRC_A] & ~src_empty[SRC_B];

  // Equal-index heads go A first so the younger B value lands last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_A;
    if (contested) begin
      gnt_vld = 1'b1;
      if (head_wr[SRC_A] == head_wr[SRC_B]) gnt_src = SRC_A;
      else gnt_src = (rr_last == SRC_A) ? SRC_B : SRC_A;
    end else if (!src_empty[SRC_A]) begin
      gnt_vld = 1'b1;
      gnt_src = SRC_A;
    end else if (!src_empty[SRC_B]) begin
      gnt_vld = 1'b1;
      gnt_src = SRC_B;
    end
  end

  always_comb begin
    src_pop = '0;
    if (gnt_vld) src_pop[gnt_src] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write   <= 1'b0;
      WR      <= '0;
      WD      <= '0;
      rr_last <= SRC_B;
    end else begin
      write <= gnt_vld;
      if (gnt_vld) begin
        WR <= head_wr[gnt_src];
        WD <= head_wd[gnt_src];
      end
      if (gnt_vld && contested) rr_last <= gnt_src;
    end
  end

  assign pend_cnt = src_cnt[SRC_A] + src_cnt[SRC_B];
  // Taken from the empty flags so a full 2x8 configuration cannot alias to 0.
  assign busy     = ~(src_empty[SRC_A] & src_empty[SRC_B]) | write;

`ifdef RF_WB_ARB_FWD_EN
  logic [1:0][RF_ADDR_W-1:0] fwd_pr;
  logic [1:0]                fwd_hit;
  logic [1:0][DATA_W-1:0]    fwd_data;

  assign fwd_pr = {PR2, PR1};

  // Later matches override earlier ones: output stage, A oldest..youngest,
  // then B oldest..youngest.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int p = 0; p < 2; p++) begin
      if (write && (WR == fwd_pr[p])) begin
        fwd_hit[p]  = 1'b1;
        fwd_data[p] = WD;
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_vld[s][i] && (ent_wr[s][i] == fwd_pr[p])) begin
            fwd_hit[p]  = 1'b1;
            fwd_data[p] = ent_wd[s][i];
          end
        end
      end
      if (fwd_pr[p] == '0) begin
        fwd_hit[p]  = 1'b0;
        fwd_data[p] = '0;
      end
    end
  end

  assign fwd1_hit  = fwd_hit[0];
  assign fwd1_data = fwd_data[0];
  assign fwd2_hit  = fwd_hit[1];
  assign fwd2_data = fwd_data[1];
`else
  logic unused_fwd;
  assign unused_fwd = ^{PR1, PR2, ent_vld, ent_wr, ent_wd};
  assign fwd1_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_hit  = 1'b0;
  assign fwd2_data = '0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: queue-level reference model at posedge,
// decoupled monitor comparing DUT outputs at negedge.
module tb_rf_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid, a_ready, b_ready;
  logic [4:0]        a_WR, b_WR, WR, PR1, PR2;
  logic [DATA_W-1:0] a_WD, b_WD, WD, fwd1_data, fwd2_data;
  logic              write, busy, fwd1_hit, fwd2_hit;
  logic [3:0]        pend_cnt;

  rf_wb_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_WR(a_WR), .a_WD(a_WD), .a_ready(a_ready),
    .b_valid(b_valid), .b_WR(b_WR), .b_WD(b_WD), .b_ready(b_ready),
    .write(write), .WR(WR), .WD(WD), .pend_cnt(pend_cnt), .busy(busy),
    .PR1(PR1), .PR2(PR2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] wr; logic [31:0] wd; } ent_t;
  typedef struct { logic [4:0] wr; logic [31:0] wd; int cyc; } exp_t;

  ent_t        qa[$], qb[$];
  exp_t        sb[$];
  int          cyc = 0;
  bit          last_b = 1'b1;
  logic        m_vld = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] rf [32];
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Youngest queued/outgoing write to pr: B queue, then A queue, then output.
  task automatic model_fwd(input logic [4:0] pr, output bit hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (pr != 0) begin
      if (m_vld && m_wr == pr) begin hit = 1'b1; d = m_wd; end
      foreach (qa[i]) if (qa[i].wr == pr) begin hit = 1'b1; d = qa[i].wd; end
      foreach (qb[i]) if (qb[i].wr == pr) begin hit = 1'b1; d = qb[i].wd; end
    end
  endtask

  always @(posedge clk) begin : model
    ent_t e;
    int   g;
    bit   ra, rb;
    if (rst) begin
      qa.delete();
      qb.delete();
      last_b = 1'b1;
      m_vld  = 1'b0;
      m_wr   = '0;
      m_wd   = '0;
    end else begin
      ra = qa.size() < DEPTH;
      rb = qb.size() < DEPTH;
      g  = -1;
      if (qa.size() > 0 && qb.size() > 0) begin
        if (qa[0].wr == qb[0].wr) g = 0;
        else g = last_b ? 0 : 1;
        last_b = (g == 1);
      end else if (qa.size() > 0) g = 0;
      else if (qb.size() > 0) g = 1;
      if (g == 0) e = qa.pop_front();
      else if (g == 1) e = qb.pop_front();
      if (g >= 0) begin
        sb.push_back('{e.wr, e.wd, cyc + 1});
        m_vld = 1'b1;
        m_wr  = e.wr;
        m_wd  = e.wd;
      end else begin
        m_vld = 1'b0;
      end
      if (a_valid && ra && a_WR != 0) qa.push_back('{a_WR, a_WD});
      if (b_valid && rb && b_WR != 0) qb.push_back('{b_WR, b_WD});
    end
    cyc++;
  end

  always @(negedge clk) begin : monitor
    bit          ew, h;
    exp_t        x;
    logic [31:0] d;
    ew = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("write", write, ew);
    if (ew) begin
      x = sb.pop_front();
      if (write) begin
        chk("WR", WR, x.wr);
        chk("WD", WD, x.wd);
        rf[WR] = WD;
      end
    end else if (!write) begin
      chk("WR_hold", WR, m_wr);
      chk("WD_hold", WD, m_wd);
    end
    chk("a_ready", a_ready, !rst && qa.size() < DEPTH);
    chk("b_ready", b_ready, !rst && qb.size() < DEPTH);
    chk("pend_cnt", pend_cnt, qa.size() + qb.size());
    chk("busy", busy, (qa.size() + qb.size()) > 0 || m_vld);
`ifdef RF_WB_ARB_FWD_EN
    model_fwd(PR1, h, d);
    chk("fwd1_hit", fwd1_hit, h);
    if (h) chk("fwd1_data", fwd1_data, d);
    model_fwd(PR2, h, d);
    chk("fwd2_hit", fwd2_hit, h);
    if (h) chk("fwd2_data", fwd2_data, d);
`else
    chk("fwd1_hit", fwd1_hit, 0);
    chk("fwd1_data", fwd1_data, 0);
    chk("fwd2_hit", fwd2_hit, 0);
    chk("fwd2_data", fwd2_data, 0);
`endif
  end

  task automatic step(input bit av, input logic [4:0] aw, input logic [31:0] ad,
                      input bit bv, input logic [4:0] bw, input logic [31:0] bd);
    a_valid = av; a_WR = aw; a_WD = ad;
    b_valid = bv; b_WR = bw; b_WD = bd;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1;
    PR1 = '0;
    PR2 = '0;
    a_valid = 0; a_WR = 0; a_WD = 0;
    b_valid = 0; b_WR = 0; b_WD = 0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    // single write, then contention, then same-index collision
    step(1, 4, 31, 0, 0, 0);
    idle(4);
    repeat (4) step(1, 5, 10, 1, 6, 20);
    idle(8);
    step(1, 7, 1, 1, 7, 2);
    idle(5);
    chk("rf7_final", rf[7], 2);

    // x0 discard
    step(0, 0, 0, 1, 0, 99);
    idle(3);

    // fill both queues then reset for one cycle
    repeat (DEPTH + 2) step(1, 9, 90, 1, 10, 100);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    idle(5);

    // forwarding lookup with the same index queued on both sources
    PR1 = 8;
    PR2 = 0;
    step(1, 8, 44, 1, 8, 55);
    idle(4);

    repeat (3000) begin
      rst = ($urandom_range(0, 99) == 0);
      PR1 = 5'($urandom_range(0, 9));
      PR2 = 5'($urandom_range(0, 9));
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom);
    end
    rst = 1'b0;
    idle(10);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
